// File: rtl/freq_div_prog.sv
// ---------------------------------------------------------------------------
// freq_div_prog
//
// Programmable multi-channel frequency divider. Each channel counts the system
// clock from 0 up to a runtime-loadable half-period (half_r) and wraps. The
// wrap cycle is the terminal count (TC). From it the channel derives:
//   - tick : a registered one-cycle pulse in the cycle after every TC
//   - fout : a 50% square wave toggling at each TC (mode=0), or a copy of tick
//            (mode=1)
// All outputs are registered in the clk domain. No derived clocks are
// produced, so downstream logic should use tick as a clock enable.
//
// A new half-period is loaded into a pending register and applied only at
// the next wrap or on clr. Because of this, the counter never runs past
// half_r and the current period is never cut short.
//
// Parameters:
//   NUM_CH       number of independent channels
//   CNT_W        counter / half-period width per channel
//   DEFAULT_HALF half-period of every channel after reset
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   en       global count enable; low freezes every channel
//   clr      synchronous phase restart of all channels (also applies pending
//            half-periods)
//   load     per-channel strobe that captures a new half-period
//   half_in  new half-periods; channel i uses bits [i*CNT_W +: CNT_W]
//   mode     per channel: 0 = square, 1 = strobe
//   fout     divided output per channel
//   tick     one-cycle terminal-count pulse per channel
// ---------------------------------------------------------------------------
module freq_div_prog #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned CNT_W        = 27,
    parameter int unsigned DEFAULT_HALF = 49999999
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*CNT_W-1:0] half_in,
    input  logic [NUM_CH-1:0]       mode,
    output logic [NUM_CH-1:0]       fout,
    output logic [NUM_CH-1:0]       tick
);

    localparam logic [CNT_W-1:0] DefaultHalf = CNT_W'(DEFAULT_HALF);
    localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

        logic [CNT_W-1:0] cnt_q,  cnt_d;
        logic [CNT_W-1:0] half_q, half_d;
        logic [CNT_W-1:0] pend_q, pend_d;
        logic             pend_v_q, pend_v_d;
        logic             fout_q, fout_d;
        logic             tick_q, tick_d;

        logic [CNT_W-1:0] half_slice;
        logic [CNT_W-1:0] half_next;
        logic             tc;

        assign half_slice = half_in[i*CNT_W +: CNT_W];

        // A counter frozen by en=0 must not raise a terminal count.
        assign tc = en && (cnt_q == half_q);

        // Half-period adopted at a wrap or clr. A load in the same cycle is
        // newer than anything already pending, so it wins.
        always_comb begin
            half_next = half_q;
            if (load[i]) begin
                half_next = half_slice;
            end else if (pend_v_q) begin
                half_next = pend_q;
            end
        end

        always_comb begin
            cnt_d    = cnt_q;
            half_d   = half_q;
            pend_d   = pend_q;
            pend_v_d = pend_v_q;
            fout_d   = fout_q;
            tick_d   = 1'b0;

            // Loads are captured even while en=0 or mid-period.
            if (load[i]) begin
                pend_d   = half_slice;
                pend_v_d = 1'b1;
            end

            if (clr) begin
                // Phase restart takes priority over TC and en.
                cnt_d    = '0;
                half_d   = half_next;
                pend_v_d = 1'b0;
                fout_d   = 1'b0;
            end else if (tc) begin
                cnt_d    = '0;
                half_d   = half_next;
                pend_v_d = 1'b0;
                tick_d   = 1'b1;
                fout_d   = mode[i] ? 1'b1 : ~fout_q;
            end else begin
                if (en) begin
                    cnt_d = cnt_q + CntOne;
                end
                // In strobe mode fout follows tick, which is low here. The
                // square wave simply holds between terminal counts.
                if (mode[i]) begin
                    fout_d = 1'b0;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q    <= '0;
                half_q   <= DefaultHalf;
                pend_q   <= '0;
                pend_v_q <= 1'b0;
                fout_q   <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                half_q   <= half_d;
                pend_q   <= pend_d;
                pend_v_q <= pend_v_d;
                fout_q   <= fout_d;
                tick_q   <= tick_d;
            end
        end

        assign fout[i] = fout_q;
        assign tick[i] = tick_q;

    end : g_ch

endmodule

// File: tb/tb_freq_div_prog.sv
module tb_freq_div_prog;

    localparam int unsigned NumCh = 2;
    localparam int unsigned CntW  = 8;

    logic                  clk;
    logic                  rst;
    logic                  en;
    logic                  clr;
    logic [NumCh-1:0]      load;
    logic [NumCh*CntW-1:0] half_in;
    logic [NumCh-1:0]      mode;
    logic [NumCh-1:0]      fout;
    logic [NumCh-1:0]      tick;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        en;
        logic        clr;
        logic [1:0]  load;
        logic [15:0] half_in;
        logic [1:0]  mode;
        logic [1:0]  fout;
        logic [1:0]  tick;
    } vec_t;

    vec_t vecs[$];

    freq_div_prog #(
        .NUM_CH       (NumCh),
        .CNT_W        (CntW),
        .DEFAULT_HALF (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .load    (load),
        .half_in (half_in),
        .mode    (mode),
        .fout    (fout),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic e, input logic c, input logic [1:0] ld,
                                input logic [15:0] h, input logic [1:0] m,
                                input logic [1:0] ef, input logic [1:0] et);
        vec_t v;
        v.en = e; v.clr = c; v.load = ld; v.half_in = h; v.mode = m;
        v.fout = ef; v.tick = et;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [1:0] ef, input logic [1:0] et);
        n_tests++;
        if (fout !== ef) begin
            n_fail++;
            $display("FAIL %s fout: got %b, expected %b", name, fout, ef);
        end
        n_tests++;
        if (tick !== et) begin
            n_fail++;
            $display("FAIL %s tick: got %b, expected %b", name, tick, et);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, clock once, compare.
    task automatic cyc(input string name, input logic e, input logic c, input logic [1:0] ld,
                       input logic [15:0] h, input logic [1:0] m,
                       input logic [1:0] ef, input logic [1:0] et);
        en = e; clr = c; load = ld; half_in = h; mode = m;
        step();
        check(name, ef, et);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; load = '0; half_in = '0; mode = '0;

        // Edges 1..11: default half=4, square mode on both channels.
        for (int k = 1; k <= 4; k++) add(1, 0, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00);
        add(1, 0, 2'b00, 16'h0000, 2'b00, 2'b11, 2'b11);
        for (int k = 6; k <= 9; k++) add(1, 0, 2'b00, 16'h0000, 2'b00, 2'b11, 2'b00);
        add(1, 0, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b11);
        add(1, 0, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00);
        // Edges 12..21: load ch0 half=1 while cnt=2; applied at the next wrap.
        add(1, 0, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00);
        add(1, 0, 2'b01, 16'h0001, 2'b00, 2'b00, 2'b00);
        add(1, 0, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00);
        add(1, 0, 2'b00, 16'h0000, 2'b00, 2'b11, 2'b11);
        add(1, 0, 2'b00, 16'h0000, 2'b00, 2'b11, 2'b00);
        add(1, 0, 2'b00, 16'h0000, 2'b00, 2'b10, 2'b01);
        add(1, 0, 2'b00, 16'h0000, 2'b00, 2'b10, 2'b00);
        add(1, 0, 2'b00, 16'h0000, 2'b00, 2'b11, 2'b01);
        add(1, 0, 2'b00, 16'h0000, 2'b00, 2'b01, 2'b10);
        add(1, 0, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b01);
        // Edges 22..28: ch1 strobe, load half=0 -> continuous high after its TC.
        add(1, 0, 2'b10, 16'h0000, 2'b10, 2'b00, 2'b00);
        add(1, 0, 2'b00, 16'h0000, 2'b10, 2'b01, 2'b01);
        add(1, 0, 2'b00, 16'h0000, 2'b10, 2'b01, 2'b00);
        add(1, 0, 2'b00, 16'h0000, 2'b10, 2'b10, 2'b11);
        add(1, 0, 2'b00, 16'h0000, 2'b10, 2'b10, 2'b10);
        add(1, 0, 2'b00, 16'h0000, 2'b10, 2'b11, 2'b11);
        add(1, 0, 2'b00, 16'h0000, 2'b10, 2'b11, 2'b10);
        // Edges 29..35: ch1 load half=2 coincident with TC -> pulse every 3.
        add(1, 0, 2'b10, 16'h0200, 2'b10, 2'b10, 2'b11);
        add(1, 0, 2'b00, 16'h0000, 2'b10, 2'b00, 2'b00);
        add(1, 0, 2'b00, 16'h0000, 2'b10, 2'b01, 2'b01);
        add(1, 0, 2'b00, 16'h0000, 2'b10, 2'b11, 2'b10);
        add(1, 0, 2'b00, 16'h0000, 2'b10, 2'b00, 2'b01);
        add(1, 0, 2'b00, 16'h0000, 2'b10, 2'b00, 2'b00);
        add(1, 0, 2'b00, 16'h0000, 2'b10, 2'b11, 2'b11);

        #1 rst = 1'b0;
        #1 check("reset_initial", 2'b00, 2'b00);
        en = 1'b1;
        step();
        check("reset_held_en1", 2'b00, 2'b00);
        step();
        check("reset_held_en1_b", 2'b00, 2'b00);
        rst = 1'b1;

        foreach (vecs[i]) begin
            cyc($sformatf("vec%0d", i + 1), vecs[i].en, vecs[i].clr, vecs[i].load,
                vecs[i].half_in, vecs[i].mode, vecs[i].fout, vecs[i].tick);
        end

        // Asynchronous reset between edges while both outputs are high.
        #3 rst = 1'b0;
        #1 check("rst_async", 2'b00, 2'b00);
        en = 1'b1; clr = 1'b0; load = '0; half_in = '0; mode = '0;
        step();
        check("rst_async_held", 2'b00, 2'b00);
        rst = 1'b1;

        // half_r must be back to 4 on both channels.
        for (int k = 1; k <= 4; k++) cyc("post_rst", 1, 0, 2'b00, 16'h0, 2'b00, 2'b00, 2'b00);
        cyc("post_rst_tc", 1, 0, 2'b00, 16'h0, 2'b00, 2'b11, 2'b11);
        for (int k = 1; k <= 3; k++) cyc("to_cnt3", 1, 0, 2'b00, 16'h0, 2'b00, 2'b11, 2'b00);

        // Freeze at cnt=3 for 7 cycles; TC lands 2 cycles after resume.
        for (int k = 1; k <= 7; k++) cyc("en_low", 0, 0, 2'b00, 16'h0, 2'b00, 2'b11, 2'b00);
        cyc("resume_1", 1, 0, 2'b00, 16'h0, 2'b00, 2'b11, 2'b00);
        cyc("resume_tc", 1, 0, 2'b00, 16'h0, 2'b00, 2'b00, 2'b11);
        for (int k = 1; k <= 4; k++) cyc("pre_clr", 1, 0, 2'b00, 16'h0, 2'b00, 2'b00, 2'b00);
        cyc("pre_clr_tc", 1, 0, 2'b00, 16'h0, 2'b00, 2'b11, 2'b11);
        for (int k = 1; k <= 2; k++) cyc("to_cnt2", 1, 0, 2'b00, 16'h0, 2'b00, 2'b11, 2'b00);

        // clr with load[1]=3 at cnt=2: restart, ch1 every 4, ch0 every 5.
        cyc("clr", 1, 1, 2'b10, 16'h0300, 2'b00, 2'b00, 2'b00);
        for (int k = 1; k <= 3; k++) cyc("clr_p", 1, 0, 2'b00, 16'h0, 2'b00, 2'b00, 2'b00);
        cyc("clr_c4", 1, 0, 2'b00, 16'h0, 2'b00, 2'b10, 2'b10);
        cyc("clr_c5", 1, 0, 2'b00, 16'h0, 2'b00, 2'b11, 2'b01);
        cyc("clr_c6", 1, 0, 2'b00, 16'h0, 2'b00, 2'b11, 2'b00);
        cyc("clr_c7", 1, 0, 2'b00, 16'h0, 2'b00, 2'b11, 2'b00);
        cyc("clr_c8", 1, 0, 2'b00, 16'h0, 2'b00, 2'b01, 2'b10);
        cyc("clr_c9", 1, 0, 2'b00, 16'h0, 2'b00, 2'b01, 2'b00);
        cyc("clr_c10", 1, 0, 2'b00, 16'h0, 2'b00, 2'b00, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_div_prog.md
Name: freq_div_prog

Overview:
- Parametrised, programmable multi-channel frequency divider; successor to the fixed single-output 1 Hz divider.
- Each of NUM_CH channels derives a square wave or a one-cycle strobe from the system clock, using a runtime-loadable half-period.
- All outputs are registered in the clk domain; no derived clocks. Downstream logic (display scan, FSM step, stopwatch) uses tick as a clock enable.
- Sits between the board clock and any block needing slow rates.

Parameters:
- NUM_CH, 2, number of independent divider channels.
- CNT_W, 27, counter/half-period width per channel.
- DEFAULT_HALF, 49999999, reset half-period for every channel (1 Hz at 100 MHz in square mode).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- en  input  1  global count enable; low freezes all channels
- clr  input  1  synchronous phase restart of all channels
- load  input  NUM_CH  per-channel strobe to capture a new half-period
- half_in  input  NUM_CH*CNT_W  new half-periods; channel i uses bits [i*CNT_W +: CNT_W]
- mode  input  NUM_CH  per channel: 0 = square, 1 = strobe
- fout  output  NUM_CH  divided output per channel
- tick  output  NUM_CH  one-cycle terminal-count pulse per channel

Behaviour:
- Reset (rst=0, asynchronous) sets, per channel: cnt=0, fout=0, tick=0, half_r=DEFAULT_HALF, pend_v=0, pend=0.
- Counting: while en=1, cnt counts 0..half_r, then wraps to 0. Terminal count (TC) is cnt==half_r && en. One TC period is half_r+1 cycles.
- tick: registered. It is high for exactly one cycle, in the cycle after each TC, i.e. on the same edge at which fout changes.
- Square mode (mode=0): fout toggles at each TC. Output period is 2*(half_r+1) cycles, 50% duty.
- Strobe mode (mode=1): fout is a copy of tick (high 1 cycle per half_r+1 cycles).
- Mode change: takes effect on the next edge. A square channel switched to strobe drops fout to 0 on the next edge unless a TC occurs on that edge.
- Half-period value 0 is legal:
  - square mode: fout toggles every cycle (clk/2);
  - strobe mode: tick and fout are held high continuously while en=1.
- load[i]=1: captures half_in slice i into pend_i and sets pend_v_i. This does not disturb the current period.
  - At the next TC, or on clr: half_r_i <= pend_i, pend_v_i <= 0, cnt <= 0.
  - Load coincident with TC: the new value is applied at that same wrap. It governs the very next period.
  - Repeated loads before a TC: last value wins.
- clr=1 (synchronous, all channels):
  - cnt <= 0, fout <= 0, tick <= 0;
  - pending values are applied; a load in the same cycle is also applied.
  - clr has priority over TC and en.
- en=0: cnt, fout and half_r hold; tick forced to 0 on the next edge. Loads are still captured into pend. Resume continues from the held cnt with no phase loss.
- Width: cnt compare is unsigned CNT_W-bit. The counter never exceeds half_r, because the new half_r is only applied at wrap/clr.
- Channels are fully independent except for shared en, clr and rst.
- Reset asserted mid-operation: all state returns to the reset values immediately, regardless of clk.

Test Plan (NUM_CH=2, CNT_W=8, DEFAULT_HALF=4):
- Release reset, en=1, mode=00 -> both fout toggle every 5 cycles (period 10). tick pulses every 5 cycles, aligned with the fout edges. fout=0 and tick=0 throughout reset.
- load[0] with half_in[7:0]=1 at cnt=2 -> ch0 finishes its current 5-cycle phase, then toggles every 2 cycles. ch1 is unchanged.
- mode[1]=1, half=0 -> fout[1] and tick[1] held high continuously. Then load half=2 -> pulses every 3 cycles starting after the next TC.
- en=0 for 7 cycles mid-phase at cnt=3 -> no tick, fout frozen. After en=1, the next TC occurs exactly 2 cycles later.
- clr asserted together with load[1]=3 while ch1 cnt=2 -> all cnt=0, fout=0 next cycle. ch1 then toggles every 4 cycles and ch0 every 5.
- rst pulled low asynchronously between clock edges mid-count -> fout, tick and cnt are 0 immediately. After release, half_r is back to 4 on both channels.
